ro_trng_sampler: RTL and testbench

- Parametrised successor to the single ring-oscillator cell.
- Instantiates NUM_RO ring oscillators of NUM_INV stages each and XORs their outputs.
- Samples the XOR into the clk domain, optionally applies von Neumann debiasing, and runs a repetition-count health test.
- Packs accepted bits into WORD_W-bit words delivered over a valid/ready interface to the RNG readout logic.

---
 rtl/ro_trng_sampler.sv | 194 +++++++++++++++++++
 tb/tb_ro_trng_sampler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ro_trng_sampler.sv
// ro_trng_sampler: ring-oscillator entropy source with a sampling and packing back end.
//   NUM_RO oscillators of NUM_INV stages are XORed, synchronised into clk, then
//   optionally von Neumann debiased. A repetition-count health test watches the raw
//   bits. Accepted bits are packed into WORD_W-bit words and offered on a valid/ready port.
// Ports:
//   clk, res          sampling clock, async active-high reset
//   en                enables oscillators and collection
//   debias_en         1 = von Neumann pairs, 0 = every raw bit accepted
//   test_mode/test_bit  deterministic substitute for the oscillator XOR
//   rdata/rvalid/rready output word handshake
//   health_fail       sticky repetition-test failure

// One oscillator lane. The inverter ring closes through a flop so the loop is
// timed and simulates deterministically; the physical entropy cell replaces this
// lane with a placed free-running macro that keeps the same ports.
module ro_cell #(
  parameter int NUM_INV = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic ro_o
);
  logic [NUM_INV-1:0] stg;
  logic               ring_q;

  assign stg[0] = ~ring_q;
  for (genvar g = 1; g < NUM_INV; g++) begin : g_inv
    assign stg[g] = ~stg[g-1];
  end

  // Disabled lanes hold their level so they draw no switching current.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ring_q <= 1'b0;
    else if (en_i) ring_q <= stg[NUM_INV-1];
  end

  assign ro_o = ring_q;
endmodule

module ro_trng_sampler #(
  parameter int NUM_RO    = 4,
  parameter int NUM_INV   = 3,
  parameter int WORD_W    = 8,
  parameter int REP_LIMIT = 32
) (
  input  logic              clk,
  input  logic              res,
  input  logic              en,
  input  logic              debias_en,
  input  logic              test_mode,
  input  logic              test_bit,
  output logic [WORD_W-1:0] rdata,
  output logic              rvalid,
  input  logic              rready,
  output logic              health_fail
);
  localparam int CW = $clog2(WORD_W + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [CW-1:0] WORD_C = CW'(WORD_W);
  localparam logic [RW-1:0] REP_C  = RW'(REP_LIMIT);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, FAIL} state_t;

  state_t              state_q;
  logic                s1_q, s2_q;
  logic                pair_v_q, pair_b_q;
  logic [WORD_W-1:0]   shreg_q, rdata_q;
  logic [CW-1:0]       cnt_q;
  logic [RW-1:0]       rep_cnt_q;
  logic                last_raw_q, rvalid_q, health_fail_q;

  // ---------------------------------------------------------------- oscillators
  logic [NUM_RO-1:0] ro_out;
  logic              ro_en;

  assign ro_en = en & ~res;

  for (genvar l = 0; l < NUM_RO; l++) begin : g_ro
    ro_cell #(.NUM_INV(NUM_INV)) u_ro (
      .clk  (clk),
      .rst_n(~res),
      .en_i (ro_en),
      .ro_o (ro_out[l])
    );
  end

  logic src;
  assign src = test_mode ? test_bit : ^ro_out;

  // ---------------------------------------------------------------- datapath helpers
  logic [RW-1:0]     rep_d;
  logic              trip;
  logic              acc, acc_bit, word_done, slot_free;
  logic [WORD_W-1:0] shreg_d;
  logic [CW-1:0]     cnt_d;

  always_comb begin
    rep_d   = (s2_q == last_raw_q) ? rep_cnt_q + RW'(1) : RW'(1);
    trip    = (rep_d == REP_C);
    acc     = 1'b0;
    acc_bit = s2_q;
    if (state_q == COLLECT) begin
      if (!debias_en) begin
        acc = 1'b1;
      end else if (pair_v_q && (pair_b_q != s2_q)) begin
        // von Neumann: 01 -> 0, 10 -> 1 (first bit of the pair)
        acc     = 1'b1;
        acc_bit = pair_b_q;
      end
    end
    shreg_d   = {shreg_q[WORD_W-2:0], acc_bit};
    cnt_d     = cnt_q + CW'(1);
    word_done = acc && (cnt_d == WORD_C);
    // The slot is free if empty or being drained on this very edge.
    slot_free = !rvalid_q || rready;
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      pair_v_q      <= 1'b0;
      pair_b_q      <= 1'b0;
      shreg_q       <= '0;
      cnt_q         <= '0;
      rep_cnt_q     <= '0;
      last_raw_q    <= 1'b0;
      rdata_q       <= '0;
      rvalid_q      <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      s1_q <= src;
      s2_q <= s1_q;

      if (state_q == FAIL) begin
        rvalid_q <= 1'b0;
      end else if (!en) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        pair_v_q  <= 1'b0;
        rep_cnt_q <= '0;
        if (rvalid_q && rready) rvalid_q <= 1'b0;
      end else begin
        rep_cnt_q  <= rep_d;
        last_raw_q <= s2_q;
        if (trip) begin
          health_fail_q <= 1'b1;
          rvalid_q      <= 1'b0;
          state_q       <= FAIL;
        end else begin
          if (rvalid_q && rready) rvalid_q <= 1'b0;
          case (state_q)
            IDLE: state_q <= COLLECT;
            COLLECT: begin
              // Raw mode keeps pair_v clear, so a debias_en toggle restarts pairing.
              pair_v_q <= debias_en ? ~pair_v_q : 1'b0;
              if (debias_en && !pair_v_q) pair_b_q <= s2_q;
              if (acc) begin
                shreg_q <= shreg_d;
                cnt_q   <= cnt_d;
                if (word_done) begin
                  if (slot_free) begin
                    rdata_q  <= shreg_d;
                    rvalid_q <= 1'b1;
                    cnt_q    <= '0;
                  end else begin
                    state_q <= FULL;
                  end
                end
              end
            end
            FULL: begin
              pair_v_q <= 1'b0;
              if (slot_free) begin
                rdata_q  <= shreg_q;
                rvalid_q <= 1'b1;
                cnt_q    <= '0;
                state_q  <= COLLECT;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign health_fail = health_fail_q;
endmodule

// File: tb/tb_ro_trng_sampler.sv
module tb_ro_trng_sampler;
  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       en = 1'b0, debias_en = 1'b0, test_mode = 1'b1, test_bit = 1'b0;
  logic       rready = 1'b0;
  logic [7:0] rdata;
  logic       rvalid, health_fail;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];

  ro_trng_sampler #(.NUM_RO(4), .NUM_INV(3), .WORD_W(8), .REP_LIMIT(32)) dut (
    .clk        (clk),
    .res        (res),
    .en         (en),
    .debias_en  (debias_en),
    .test_mode  (test_mode),
    .test_bit   (test_bit),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  // Monitor: every handshake pops one expected word.
  always @(negedge clk) begin
    if (!res && rvalid && rready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_word: got %h, no word expected", rdata);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (rdata !== e) begin
          fails++;
          $display("FAIL sb_word: got %h, expected %h", rdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; rready = 1'b0; test_bit = 1'b0; debias_en = 1'b0;
    res = 1'b1;
    tick(); tick();
    res = 1'b0;
  endtask

  // Drive n bits MSB first; optionally raise en after the first sample so the
  // first bit is the first one consumed in COLLECT.
  task automatic send(input logic [31:0] v, input int n, input bit raise_en);
    for (int i = n - 1; i >= 0; i--) begin
      test_bit = v[i];
      tick();
      if (raise_en && i == n - 1) en = 1'b1;
    end
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
    chk(nm, sb.size(), 0);
  endtask

  initial begin
    int trip_cyc;

    // 1: reset with arbitrary inputs
    res = 1'b1; en = 1'b1; debias_en = 1'b1; test_mode = 1'b1; test_bit = 1'b1; rready = 1'b1;
    tick(); tick();
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_health", health_fail, 0);

    // 2: raw mode 1,0,1,1,0,0,1,0 -> B2 at edge 10
    do_reset();
    test_mode = 1'b1; rready = 1'b1;
    sb.push_back(8'hB2);
    send(32'hB2, 8, 1'b1);
    test_bit = 1'b0;
    tick(); chk("raw_e9_rvalid", rvalid, 0);
    tick(); chk("raw_e10_rvalid", rvalid, 1); chk("raw_e10_rdata", rdata, 8'hB2);
    tick(); chk("raw_e11_rvalid", rvalid, 0);
    drain("raw_drain");

    // 3: debias pairs 01,10,11,00 x4 -> 55
    do_reset();
    debias_en = 1'b1; rready = 1'b1;
    sb.push_back(8'h55);
    send(32'h6C6C6C6C, 32, 1'b1);
    send(32'h0, 4, 1'b0);
    drain("debias_drain");
    chk("debias_rvalid_idle", rvalid, 0);

    // 4: back-pressure: AA held in rdata, 55 held in FULL, filler dropped
    do_reset();
    sb.push_back(8'hAA);
    sb.push_back(8'h55);
    send(32'hAA55, 16, 1'b1);
    send(32'hCC, 8, 1'b0);
    chk("bp_hold_rvalid", rvalid, 1);
    chk("bp_hold_rdata", rdata, 8'hAA);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("bp_next_rvalid", rvalid, 1);
    chk("bp_next_rdata", rdata, 8'h55);
    tick();
    chk("bp_stable_rdata", rdata, 8'h55);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("bp_drained_rvalid", rvalid, 0);
    chk("bp_sb_empty", sb.size(), 0);

    // 5: stuck-at-1 trips the repetition test
    do_reset();
    test_bit = 1'b1; rready = 1'b1;
    tick(); tick(); tick();
    sb.push_back(8'hFF); sb.push_back(8'hFF); sb.push_back(8'hFF);
    en = 1'b1;
    trip_cyc = 0;
    for (int c = 1; c <= 40 && trip_cyc == 0; c++) begin
      tick();
      if (health_fail) trip_cyc = c;
    end
    chk("hf_raised", health_fail, 1);
    chk("hf_trip_window", (trip_cyc >= 31 && trip_cyc <= 34), 1);
    chk("hf_rvalid", rvalid, 0);
    chk("hf_words", sb.size(), 0);
    en = 1'b0; tick(); tick(); tick();
    en = 1'b1; tick(); tick(); tick();
    chk("hf_sticky", health_fail, 1);
    chk("hf_rvalid_stays", rvalid, 0);
    #2 res = 1'b1;
    #1 chk("hf_res_clear", health_fail, 0);
    en = 1'b0; test_bit = 1'b0;
    tick();
    res = 1'b0;

    // 6: reset mid-word with a pending word
    do_reset();
    send(32'h7855, 15, 1'b1); // F0 word then 1,0,1,0,1 accepted (cnt=5)
    chk("mid_rvalid_pre", rvalid, 1);
    chk("mid_rdata_pre", rdata, 8'hF0);
    #2 res = 1'b1; en = 1'b0;
    #1 chk("mid_rvalid_clr", rvalid, 0);
    chk("mid_rdata_clr", rdata, 0);
    tick();
    res = 1'b0;
    rready = 1'b1;
    sb.push_back(8'hC3);
    send(32'hC3, 8, 1'b1);
    test_bit = 1'b0;
    tick(); chk("mid_fresh_e9", rvalid, 0);
    drain("mid_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
